// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_bus_ctrl : processor data-port decoder with per-region wait states
// Revision     : 1.0
// ----------------------------------------------------------------------------
module mem_bus_ctrl #(
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = 32,
  parameter int              NREG        = 3,
  parameter int              REGION_BITS = 14,
  parameter logic [4*NREG-1:0] WAIT_CFG  = 12'h210
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  output logic                   ready,
  output logic [DATA_W-1:0]      rdata,
  output logic                   err,
  output logic [7:0]             err_count,
  output logic [NREG-1:0]        en,
  output logic [ADDR_W-1:0]      offset,
  output logic [DATA_W-1:0]      wdata_o,
  input  logic [NREG*DATA_W-1:0] rd_data
);

  localparam int c_IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int c_NSLOT = 1 << c_IDX_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic                r_we;
  logic [c_IDX_W-1:0]  r_idx;
  logic [3:0]          r_wcnt;
  logic [REGION_BITS-1:0] r_offset;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_unmapped;
  logic [7:0]          r_err_count;

  logic [ADDR_W-1:0]   w_idx_full;
  logic                w_mapped;
  logic [c_IDX_W-1:0]  w_idx;
  logic                w_strobe;
  logic [3:0]          w_wait [c_NSLOT];
  logic [DATA_W-1:0]   w_rd   [c_NSLOT];
  logic [NREG-1:0]     w_onehot;

  // The full upper address takes part in the compare so aliases above the map stay unmapped
  assign w_idx_full = addr >> REGION_BITS;
  assign w_mapped   = (w_idx_full < ADDR_W'(NREG));
  assign w_idx      = w_idx_full[c_IDX_W-1:0];
  assign w_strobe   = (r_state == S_ACCESS) && (r_wcnt == 4'd0);

  // Unused index slots are padded so every c_IDX_W-bit index selects a defined value
  for (genvar gi = 0; gi < c_NSLOT; gi++) begin : g_slot
    if (gi < NREG) begin : g_used
      assign w_wait[gi]   = WAIT_CFG[4*gi +: 4];
      assign w_rd[gi]     = rd_data[DATA_W*gi +: DATA_W];
      assign w_onehot[gi] = (r_idx == c_IDX_W'(gi));
    end else begin : g_pad
      assign w_wait[gi] = 4'd0;
      assign w_rd[gi]   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    err    = 1'b0;
    en     = '0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_next = w_mapped ? S_ACCESS : S_RESP;
        end
      end
      S_ACCESS: begin
        if (w_strobe) begin
          w_next = S_RESP;
          if (r_we) begin
            en = w_onehot;
          end
        end
      end
      S_RESP: begin
        ready  = 1'b1;
        err    = r_unmapped;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we        <= 1'b0;
      r_idx       <= '0;
      r_wcnt      <= 4'd0;
      r_offset    <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_unmapped  <= 1'b0;
      r_err_count <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_we       <= we;
            r_idx      <= w_idx;
            r_offset   <= addr[REGION_BITS-1:0];
            r_wdata    <= wdata;
            r_unmapped <= !w_mapped;
            if (w_mapped) begin
              r_wcnt <= w_wait[w_idx];
            end else begin
              r_wcnt  <= 4'd0;
              r_rdata <= '0;
              if (r_err_count != 8'hFF) begin
                r_err_count <= r_err_count + 8'd1;
              end
            end
          end
        end
        S_ACCESS: begin
          if (r_wcnt == 4'd0) begin
            if (!r_we) begin
              r_rdata <= w_rd[r_idx];
            end
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rdata     = r_rdata;
  assign err_count = r_err_count;
  assign offset    = ADDR_W'(r_offset);
  assign wdata_o   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mem_bus_ctrl : directed and randomized bench for mem_bus_ctrl
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic [7:0]  err_count;
  logic [2:0]  en;
  logic [31:0] offset;
  logic [31:0] wdata_o;
  logic [95:0] rd_data;

  logic [31:0] rmem [3];
  int          waits [3] = '{0, 1, 2};

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rdata = 32'd0;
  int          exp_errcnt = 0;

  assign rd_data = {rmem[2], rmem[1], rmem[0]};

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .rdata     (rdata),
    .err       (err),
    .err_count (err_count),
    .en        (en),
    .offset    (offset),
    .wdata_o   (wdata_o),
    .rd_data   (rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 3; i++) rmem[i] = $urandom;
  endtask

  // One complete processor transaction, checked cycle by cycle against the map rules
  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d);
    logic [31:0] ix;
    bit          mapped;
    int          lat;
    int          cyc;
    bit          seen;
    logic [2:0]  exp_en;
    ix     = a >> 14;
    mapped = (ix < 32'd3);
    lat    = mapped ? waits[ix[1:0]] + 2 : 1;
    if (mapped && !w) exp_rdata = rmem[ix[1:0]];
    else if (!mapped) begin
      exp_rdata = 32'd0;
      if (exp_errcnt < 255) exp_errcnt++;
    end
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      exp_en = (w && mapped && cyc == lat - 1) ? (3'b001 << ix[1:0]) : 3'b000;
      chk("en", en, exp_en);
      chk("ready", ready, cyc == lat);
      chk("err", err, (cyc == lat) && !mapped);
      if (cyc == 1) begin
        chk("offset_c1", offset, {18'd0, a[13:0]});
        chk("wdata_o_c1", wdata_o, d);
      end
      if (ready) begin
        seen = 1'b1;
        chk("rdata", rdata, exp_rdata);
        chk("err_count", err_count, exp_errcnt);
        chk("offset", offset, {18'd0, a[13:0]});
        req = 1'b0;
      end
    end
    chk("ready_seen", seen, 1'b1);
    req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          r;
    rst = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    for (int i = 0; i < 3; i++) rmem[i] = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_en", en, 3'b000);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err_count", err_count, 8'd0);
    chk("rst_offset", offset, 32'd0);
    chk("rst_wdata_o", wdata_o, 32'd0);
    rst = 1'b1;

    // Directed transactions from the map definition
    randomize_mem(); rmem[0] = 32'hDEADBEEF;
    access(32'h0000_0010, 1'b0, 32'd0);
    randomize_mem();
    access(32'h0000_4004, 1'b1, 32'h12345678);
    randomize_mem(); rmem[2] = 32'h0000_01FF;
    access(32'h0000_8008, 1'b0, 32'd0);
    access(32'h0000_C000, 1'b0, 32'd0);
    access(32'h0001_4000, 1'b0, 32'd0);
    access(32'hFFFF_C000, 1'b1, 32'hCAFE0000);
    randomize_mem();
    access(32'h0000_3FFF, 1'b0, 32'd0);

    // Randomized mix of mapped, just-unmapped and arbitrary addresses
    for (int n = 0; n < 60; n++) begin
      randomize_mem();
      r = $urandom_range(0, 5);
      if (r < 3)       a = (32'(r) << 14) | 32'($urandom_range(0, 16383));
      else if (r == 3) a = 32'h0000_C000 | 32'($urandom_range(0, 16383));
      else             a = $urandom;
      access(a, 1'($urandom_range(0, 1)), $urandom);
    end

    // Make rdata and err_count non-zero, then reset in the middle of a write
    access(32'h0000_C010, 1'b0, 32'd0);
    randomize_mem(); rmem[0] = 32'hA5A50001;
    access(32'h0000_0020, 1'b0, 32'd0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h0000_8000; wdata = 32'h0BADF00D;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_en_c1", en, 3'b000);
    chk("rstmid_ready_c1", ready, 1'b0);
    @(negedge clk);
    chk("rstmid_en_c2", en, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    req = 1'b0;
    exp_rdata  = 32'd0;
    exp_errcnt = 0;
    chk("rstmid_ready", ready, 1'b0);
    chk("rstmid_err", err, 1'b0);
    chk("rstmid_en", en, 3'b000);
    chk("rstmid_rdata", rdata, 32'd0);
    chk("rstmid_err_count", err_count, 8'd0);
    chk("rstmid_offset", offset, 32'd0);
    chk("rstmid_wdata_o", wdata_o, 32'd0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rstmid_post_en", en, 3'b000);
      chk("rstmid_post_ready", ready, 1'b0);
    end

    // Saturation of the unmapped-access counter
    for (int n = 0; n < 300; n++) begin
      access(32'h0000_C000 + 32'(n), 1'($urandom_range(0, 1)), $urandom);
    end
    randomize_mem();
    access(32'h0000_0000, 1'b0, 32'd0);
    chk("sat_err_count", err_count, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Parametrised memory-map controller between the processor data port and the data-side memories (RAM, image ROM, peripheral block). It decodes the processor address into NREG equal-sized regions and generates one-hot write enables and region-relative offsets. It inserts a configurable number of wait states per region, registers the selected read data, and reports accesses to unmapped addresses with an error flag and a saturating error counter.

## Interface
Parameters:
- DATA_W, 32, data width.
- ADDR_W, 32, address width.
- NREG, 3, number of mapped regions; region i spans [i<<REGION_BITS, (i+1)<<REGION_BITS).
- REGION_BITS, 14, log2 of region size (16384 words).
- WAIT_CFG, 12'h210, packed 4-bit wait-state counts, region i in bits [4i+3:4i]; default is RAM 0, image ROM 1, peripherals 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low.
- req  in  1  processor access request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; sampled with req.
- addr  in  ADDR_W  byte/word address; sampled with req.
- wdata  in  DATA_W  write data; sampled with req.
- ready  out  1  one-cycle pulse: access complete.
- rdata  out  DATA_W  registered read data; valid while ready=1, held until next RESP.
- err  out  1  high with ready when the access was unmapped.
- err_count  out  8  saturating count of unmapped accesses.
- en  out  NREG  one-hot region write enable.
- offset  out  ADDR_W  addr[REGION_BITS-1:0], zero-extended; held from the latched address.
- wdata_o  out  DATA_W  latched write data to the regions.
- rd_data  in  NREG*DATA_W  region read data, region i in slice [DATA_W*i +: DATA_W].

## Operation
- FSM states are IDLE, ACCESS and RESP.
- IDLE with req=1:
  - Latch we, addr and wdata.
  - Compute idx = addr >> REGION_BITS.
  - If idx < NREG: load wcnt = WAIT_CFG[idx] and go to ACCESS.
  - Otherwise (unmapped): go directly to RESP with the error flag set.
- IDLE with req=0: stay in IDLE.
- ACCESS lasts WAIT_CFG[idx]+1 cycles; wcnt decrements each cycle.
  - Last ACCESS cycle (wcnt==0) is the strobe cycle:
    - Write: en[idx]=1 for exactly this cycle.
    - Read: rd_data slice idx is captured into rdata at the end of this cycle.
  - Go to RESP.
- RESP lasts one cycle: ready=1. Then go to IDLE.
  - Write: rdata keeps its previous value.
  - Unmapped: rdata=0, err=1, err_count increments unless it is already 255.
- offset and wdata_o are driven from the latched values in all states. Regions must not treat them as a strobe.
- en is 0 except in the write strobe cycle. Only one bit is ever set.
- A req asserted outside IDLE is ignored. The processor holds req until it sees ready and drops it in the same cycle.

## Timing
- The req-sampling edge is cycle 0.
- Mapped access: ready at cycle WAIT_CFG[idx]+2.
- Unmapped access: ready at cycle 1.
- Next request is accepted no earlier than the cycle after ready (IDLE).
- Reset (rst=0 at an edge), in any state including mid-ACCESS:
  - Next state is IDLE.
  - ready=0, err=0, en=0, rdata=0, err_count=0, offset=0, wdata_o=0, wcnt=0.
  - No pending write is committed.
- wcnt is 4 bits wide; a wait count of 15 gives 16 ACCESS cycles.
- The idx comparison uses the full upper address bits, so any address ≥ NREG<<REGION_BITS is unmapped.

## Test plan
Defaults throughout; timing is counted from cycle 0 = req sampled.
- Read RAM: addr=0x10, rd_data region0=0xDEADBEEF -> ACCESS at cycle 1, ready=1 at cycle 2, rdata=0xDEADBEEF, offset=0x10, err=0, en=0 throughout.
- Write image ROM region: addr=0x4004, wdata=0x12345678 -> offset=0x4, wdata_o=0x12345678 from cycle 1, en=3'b010 only in cycle 2, ready at cycle 3, rdata unchanged.
- Read peripherals: addr=0x8008, rd_data region2=0x1FF -> ready at cycle 4, rdata=0x1FF, offset=0x8.
- Unmapped read: addr=0xC000 -> ready=1 and err=1 at cycle 1, rdata=0, en=0, err_count 0->1.
- Reset mid-access: write to 0x8000, rst=0 sampled at cycle 2 -> IDLE at cycle 3, en never asserted, no ready pulse, all outputs 0.
- Saturation: 300 back-to-back unmapped accesses -> err_count reaches 255 and stays; a following mapped read of 0x0 gives err=0, err_count=255.
